// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC redirect priority, IF/ID pipeline
// register and exception return address (epc) for a 5-stage MIPS-like core.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        illegal,
    input  logic        eret,
    input  logic        irq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        flush_ex,
    output logic [31:0] epc
);

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_EXC    = 3'd2;
    localparam logic [2:0] SEL_ERET   = 3'd3;
    localparam logic [2:0] SEL_JUMP   = 3'd4;
    localparam logic [2:0] SEL_JR     = 3'd5;
    localparam logic [2:0] SEL_IRQ    = 3'd6;
    localparam logic [2:0] SEL_HOLD   = 3'd7;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [2:0]      sel;
    logic            kernel;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr_next;
    logic [XLEN-1:0] pp4_next;
    logic            valid_next;
    logic [XLEN-1:0] epc_next;

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign kernel    = pc[XLEN-1];

    // Redirect priority; ID-stage requests only count when ID holds a real instruction.
    always_comb begin
        sel = SEL_SEQ;
        if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (if_id_valid && illegal) begin
            sel = SEL_EXC;
        end else if (if_id_valid && eret) begin
            sel = SEL_ERET;
        end else if (if_id_valid && (pc_src == 2'b01)) begin
            sel = SEL_JUMP;
        end else if (if_id_valid && (pc_src == 2'b11)) begin
            sel = SEL_JR;
        end else if (irq && !kernel && !stall) begin
            sel = SEL_IRQ;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    // Branch and illegal squash the instruction currently in ID.
    assign flush_ex = !reset && ((sel == SEL_BRANCH) || (sel == SEL_EXC));

    // Next-state values; every redirect inserts one bubble into IF/ID.
    always_comb begin
        pc_next    = pc_plus4;
        instr_next = imem_rdata;
        pp4_next   = pc_plus4;
        valid_next = 1'b1;
        epc_next   = epc;
        unique case (sel)
            SEL_BRANCH: pc_next = branch_target;
            SEL_EXC: begin
                pc_next  = EXC_VEC;
                epc_next = if_id_pc_plus4;
            end
            SEL_ERET:   pc_next = {1'b0, epc[XLEN-2:0]};
            SEL_JUMP:   pc_next = {if_id_pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00};
            // jr keeps the caller's privilege bit so user code cannot jump into kernel space
            SEL_JR:     pc_next = {if_id_pc_plus4[XLEN-1], jr_target[XLEN-2:0]};
            SEL_IRQ: begin
                pc_next  = IRQ_VEC;
                epc_next = pc;
            end
            SEL_HOLD: begin
                pc_next    = pc;
                instr_next = if_id_instr;
                pp4_next   = if_id_pc_plus4;
                valid_next = if_id_valid;
            end
            default: begin
                pc_next = pc_plus4;
            end
        endcase
        if ((sel != SEL_SEQ) && (sel != SEL_HOLD)) begin
            instr_next = '0;
            pp4_next   = '0;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            epc            <= '0;
        end else begin
            pc             <= pc_next;
            if_id_instr    <= instr_next;
            if_id_pc_plus4 <= pp4_next;
            if_id_valid    <= valid_next;
            epc            <= epc_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal;
    logic        eret;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        flush_ex;
    logic [31:0] epc;

    logic [31:0] rom_word;
    assign imem_rdata = rom_word;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic [31:0] epc;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;

    localparam logic [31:0] W = 32'h2008_0001;
    localparam logic [31:0] N = 32'h8C22_0004;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_src        (pc_src),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .illegal       (illegal),
        .eret          (eret),
        .irq           (irq),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .flush_ex      (flush_ex),
        .epc           (epc)
    );

    always #5 clk = ~clk;

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, req);
        end
    endtask

    // Monitor: state visible in a cycle plus flush_ex for that cycle's inputs.
    always @(negedge clk) begin
        if (mon_on && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp32("imem_addr", imem_addr, e.pc);
            cmp32("if_id_instr", if_id_instr, e.instr);
            cmp32("if_id_pc_plus4", if_id_pc_plus4, e.pp4);
            cmp32("if_id_valid", 32'(if_id_valid), 32'(e.valid));
            cmp32("epc", epc, e.epc);
            cmp32("flush_ex", 32'(flush_ex), 32'(e.flush));
        end
    end

    task automatic idle();
        reset = 1'b0; stall = 1'b0; pc_src = 2'b00; jump_index = '0; jr_target = '0;
        branch_taken = 1'b0; branch_target = '0; illegal = 1'b0; eret = 1'b0; irq = 1'b0;
    endtask

    // Push the expectation for the current cycle, clock once, then return inputs to idle.
    task automatic cyc(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pp4,
                       input logic valid, input logic [31:0] e_epc, input logic flush);
        exp_t e;
        e = '{pc: pc, instr: instr, pp4: pp4, valid: valid, epc: e_epc, flush: flush};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic br(input logic [31:0] tgt);
        branch_taken = 1'b1;
        branch_target = tgt;
    endtask

    initial begin
        idle();
        rom_word = W;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // reset wins over a simultaneous branch; flush_ex suppressed
        reset = 1'b1; br(32'h0040_0040);
        cyc(32'h8000_0000, 0, 0, 0, 0, 0);
        // three free cycles from reset
        cyc(32'h8000_0000, 0, 0, 0, 0, 0);
        cyc(32'h8000_0004, W, 32'h8000_0004, 1, 0, 0);
        cyc(32'h8000_0008, W, 32'h8000_0008, 1, 0, 0);
        br(32'h0040_000C);
        cyc(32'h8000_000C, W, 32'h8000_000C, 1, 0, 1);
        cyc(32'h0040_000C, 0, 0, 0, 0, 0);
        // j with jump_index 0x0100040 from PC 00400010
        pc_src = 2'b01; jump_index = 26'h010_0040;
        cyc(32'h0040_0010, W, 32'h0040_0010, 1, 0, 0);
        cyc(32'h0040_0100, 0, 0, 0, 0, 0);
        // branch beats a same-cycle jump
        br(32'h0040_0040); pc_src = 2'b01; jump_index = 26'h010_0040;
        cyc(32'h0040_0104, W, 32'h0040_0104, 1, 0, 1);
        cyc(32'h0040_0040, 0, 0, 0, 0, 0);
        br(32'h0040_001C);
        cyc(32'h0040_0044, W, 32'h0040_0044, 1, 0, 1);
        cyc(32'h0040_001C, 0, 0, 0, 0, 0);
        // stall for two cycles with irq pending, then irq taken
        stall = 1'b1; irq = 1'b1;
        cyc(32'h0040_0020, W, 32'h0040_0020, 1, 0, 0);
        stall = 1'b1; irq = 1'b1;
        cyc(32'h0040_0020, W, 32'h0040_0020, 1, 0, 0);
        irq = 1'b1;
        cyc(32'h0040_0020, W, 32'h0040_0020, 1, 0, 0);
        cyc(32'h8000_0004, 0, 0, 0, 32'h0040_0020, 0);
        // irq ignored in kernel mode
        irq = 1'b1;
        cyc(32'h8000_0008, W, 32'h8000_0008, 1, 32'h0040_0020, 0);
        cyc(32'h8000_000C, W, 32'h8000_000C, 1, 32'h0040_0020, 0);
        br(32'h0040_0024);
        cyc(32'h8000_0010, W, 32'h8000_0010, 1, 32'h0040_0020, 1);
        // illegal/eret ignored while ID holds a bubble
        illegal = 1'b1; eret = 1'b1;
        cyc(32'h0040_0024, 0, 0, 0, 32'h0040_0020, 0);
        illegal = 1'b1;
        cyc(32'h0040_0028, W, 32'h0040_0028, 1, 32'h0040_0020, 1);
        cyc(32'h8000_0008, 0, 0, 0, 32'h0040_0028, 0);
        eret = 1'b1;
        cyc(32'h8000_000C, W, 32'h8000_000C, 1, 32'h0040_0028, 0);
        cyc(32'h0040_0028, 0, 0, 0, 32'h0040_0028, 0);
        br(32'h0040_0000);
        cyc(32'h0040_002C, W, 32'h0040_002C, 1, 32'h0040_0028, 1);
        rom_word = N;
        cyc(32'h0040_0000, 0, 0, 0, 32'h0040_0028, 0);
        // jr into kernel space masked; redirect overrides stall
        pc_src = 2'b11; jr_target = 32'h8000_1000; stall = 1'b1;
        cyc(32'h0040_0004, N, 32'h0040_0004, 1, 32'h0040_0028, 0);
        cyc(32'h0000_1000, 0, 0, 0, 32'h0040_0028, 0);
        // pc_src 10 behaves as sequential
        pc_src = 2'b10; jump_index = 26'h3FF_FFFF;
        cyc(32'h0000_1004, N, 32'h0000_1004, 1, 32'h0040_0028, 0);
        br(32'hFFFF_FFF8);
        cyc(32'h0000_1008, N, 32'h0000_1008, 1, 32'h0040_0028, 1);
        cyc(32'hFFFF_FFF8, 0, 0, 0, 32'h0040_0028, 0);
        cyc(32'hFFFF_FFFC, N, 32'hFFFF_FFFC, 1, 32'h0040_0028, 0);
        // reset during stall clears everything including epc
        reset = 1'b1; stall = 1'b1;
        cyc(32'h0000_0000, N, 32'h0000_0000, 1, 32'h0040_0028, 0);
        cyc(32'h8000_0000, 0, 0, 0, 0, 0);
        cyc(32'h8000_0004, N, 32'h8000_0004, 1, 0, 0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
